// File: rtl/branch_predict_unit_if.sv
// Fetch-side lookup and resolve-side branch signals shared by the pipeline
// (master) and the branch predict unit (slave).
interface branch_predict_unit_if #(
   parameter int XLEN = 32
);
   // ex_valid qualifies every ex_* input for the current cycle; there is no
   // back-pressure, so a valid resolve is consumed on the edge it is presented.
   logic [XLEN-1:0] if_pc;
   logic            if_pred_taken;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [2:0]      ex_branch;
   logic            ex_unsigned;
   logic [XLEN-1:0] ex_rs1;
   logic [XLEN-1:0] ex_rs2;
   logic            ex_pred_taken;
   logic            ex_pc_a_src;
   logic            ex_pc_b_src;
   logic            ex_mispredict;

   modport master (
      output if_pc, ex_valid, ex_pc, ex_branch, ex_unsigned, ex_rs1, ex_rs2, ex_pred_taken,
      input  if_pred_taken, ex_pc_a_src, ex_pc_b_src, ex_mispredict
   );

   modport slave (
      input  if_pc, ex_valid, ex_pc, ex_branch, ex_unsigned, ex_rs1, ex_rs2, ex_pred_taken,
      output if_pred_taken, ex_pc_a_src, ex_pc_b_src, ex_mispredict
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch condition resolve, PC-indexed 2-bit BHT prediction/training and
// saturating branch/mispredict statistics.
module branch_predict_unit #(
   parameter int         XLEN        = 32,
   parameter int         BHT_ENTRIES = 64,
   parameter logic [1:0] RESET_STATE = 2'b01,
   parameter int         STAT_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   branch_predict_unit_if.slave bus,
   output logic [STAT_W-1:0]   stat_branches,
   output logic [STAT_W-1:0]   stat_mispredicts
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic [1:0]       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [XLEN-1:0]  rs1;
   logic [XLEN-1:0]  rs2;
   logic             zero;
   logic             less;
   logic             taken;
   logic             pc_b_src;
   logic             mispredict;
   logic             conditional;
   logic             update;
   logic [1:0]       ctr_cur;
   logic [1:0]       ctr_next;
   logic             unused_pc_bits;

   assign if_idx = bus.if_pc[IDX_W+1:2];
   assign ex_idx = bus.ex_pc[IDX_W+1:2];
   // Word-offset and high PC bits only alias entries, they never select.
   assign unused_pc_bits = ^{bus.if_pc, bus.ex_pc};

   assign rs1  = bus.ex_rs1;
   assign rs2  = bus.ex_rs2;
   assign zero = (rs1 == rs2);
   assign less = bus.ex_unsigned ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));

   assign conditional = bus.ex_branch[2];

   always_comb begin
      taken      = 1'b0;
      pc_b_src   = 1'b0;
      mispredict = 1'b0;
      if (bus.ex_valid) begin
         case (bus.ex_branch)
            3'b001:  taken = 1'b1;
            3'b010: begin
               taken    = 1'b1;
               pc_b_src = 1'b1;
            end
            3'b100:  taken = zero;
            3'b101:  taken = ~zero;
            3'b110:  taken = less;
            3'b111:  taken = ~less;
            default: taken = 1'b0;
         endcase
         if (conditional)
            mispredict = (bus.ex_pred_taken != taken);
         else if (bus.ex_branch == 3'b001 || bus.ex_branch == 3'b010)
            mispredict = ~bus.ex_pred_taken;
         else
            mispredict = bus.ex_pred_taken;
      end
   end

   assign bus.ex_pc_a_src   = taken;
   assign bus.ex_pc_b_src   = pc_b_src;
   assign bus.ex_mispredict = mispredict;

   // Array read is pre-edge, so a same-index update shows up next cycle.
   assign bus.if_pred_taken = bht[if_idx][1];

   assign update  = bus.ex_valid & conditional;
   assign ctr_cur = bht[ex_idx];

   always_comb begin
      ctr_next = ctr_cur;
      if (taken) begin
         if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
      end else begin
         if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i[IDX_W-1:0]] <= RESET_STATE;
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (update) begin
         bht[ex_idx] <= ctr_next;
         if (stat_branches != STAT_MAX) stat_branches <= stat_branches + STAT_ONE;
         if (mispredict && stat_mispredicts != STAT_MAX)
            stat_mispredicts <= stat_mispredicts + STAT_ONE;
      end
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: reference model, expected
// queue of resolve/prediction outputs, and a small-counter second instance.
module tb_branch_predict_unit;
   logic clk = 1'b0;
   logic rst;
   logic [15:0] stat_branches, stat_mispredicts;
   logic [3:0]  stat4_branches, stat4_mispredicts;

   branch_predict_unit_if #(.XLEN(32)) bus ();
   branch_predict_unit_if #(.XLEN(32)) bus4 ();

   branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(64), .RESET_STATE(2'b01), .STAT_W(16)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave),
      .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
   );

   branch_predict_unit #(.XLEN(32), .BHT_ENTRIES(2), .RESET_STATE(2'b01), .STAT_W(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4.slave),
      .stat_branches(stat4_branches), .stat_mispredicts(stat4_mispredicts)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // {if_pred_taken, pc_a_src, pc_b_src, mispredict}
   logic [3:0] exp_q[$];
   logic [1:0] m_bht [64];
   int         m_br;
   int         m_mis;

   function automatic logic [5:0] idx_of(logic [31:0] pc);
      return pc[7:2];
   endfunction

   function automatic logic [2:0] model_out(logic v, logic [2:0] br, logic uns,
                                            logic [31:0] a, logic [31:0] b, logic p);
      logic t, pb, m, lt;
      lt = uns ? (a < b) : ($signed(a) < $signed(b));
      t = 1'b0; pb = 1'b0; m = 1'b0;
      if (v) begin
         if (br == 3'b001 || br == 3'b010) begin
            t = 1'b1; pb = (br == 3'b010); m = ~p;
         end else if (br[2]) begin
            t = br[1] ? (lt ^ br[0]) : ((a == b) ^ br[0]);
            m = p ^ t;
         end else begin
            m = p;
         end
      end
      return {t, pb, m};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
      m_br = 0;
      m_mis = 0;
   endtask

   // Applies the edge that just happened to the model, from the inputs held.
   task automatic model_commit();
      logic [2:0] o;
      logic [5:0] k;
      if (bus.ex_valid && bus.ex_branch[2]) begin
         o = model_out(1'b1, bus.ex_branch, bus.ex_unsigned, bus.ex_rs1, bus.ex_rs2, bus.ex_pred_taken);
         k = idx_of(bus.ex_pc);
         if (o[2] && m_bht[k] != 2'b11) m_bht[k] = m_bht[k] + 2'd1;
         if (!o[2] && m_bht[k] != 2'b00) m_bht[k] = m_bht[k] - 2'd1;
         if (m_br < 65535) m_br++;
         if (o[0] && m_mis < 65535) m_mis++;
      end
   endtask

   task automatic drive(input logic v, input logic [2:0] br, input logic uns,
                        input logic [31:0] a, input logic [31:0] b, input logic p,
                        input logic [31:0] pc, input logic [31:0] fpc);
      bus.ex_valid = v; bus.ex_branch = br; bus.ex_unsigned = uns;
      bus.ex_rs1 = a; bus.ex_rs2 = b; bus.ex_pred_taken = p;
      bus.ex_pc = pc; bus.if_pc = fpc;
      exp_q.push_back({m_bht[idx_of(fpc)][1], model_out(v, br, uns, a, b, p)});
   endtask

   task automatic idle();
      bus.ex_valid = 1'b0; bus.ex_branch = 3'b000; bus.ex_pred_taken = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      bus.ex_unsigned = 1'b0; bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_pc = '0;
      bus.if_pc = 32'h100;
      bus4.ex_valid = 1'b0; bus4.ex_branch = 3'b000; bus4.ex_unsigned = 1'b0;
      bus4.ex_rs1 = '0; bus4.ex_rs2 = '0; bus4.ex_pred_taken = 1'b0;
      bus4.ex_pc = '0; bus4.if_pc = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++;
      if (bus.if_pred_taken !== 1'b0) begin
         fails++; $display("FAIL reset_pred: got %b want 0", bus.if_pred_taken);
      end
      tests++;
      if (stat_branches !== 16'd0) begin
         fails++; $display("FAIL reset_stat_br: got %0d want 0", stat_branches);
      end
      tests++;
      if (stat_mispredicts !== 16'd0) begin
         fails++; $display("FAIL reset_stat_mis: got %0d want 0", stat_mispredicts);
      end
   endtask

   typedef struct packed {
      logic        v;
      logic [2:0]  br;
      logic        uns;
      logic [31:0] a;
      logic [31:0] b;
      logic        p;
      logic [31:0] pc;
   } vec_t;

   // Drives each vector for one cycle, checks it before the edge, commits after.
   task automatic run_vectors(input string name, input vec_t vecs[$], input logic [31:0] fpc);
      logic [3:0] e;
      logic [3:0] got;
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].v, vecs[i].br, vecs[i].uns, vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].pc, fpc);
         #1;
         e = exp_q.pop_front();
         got = {bus.if_pred_taken, bus.ex_pc_a_src, bus.ex_pc_b_src, bus.ex_mispredict};
         tests++;
         if (got !== e) begin
            fails++;
            $display("FAIL %s[%0d] pred/a/b/mis: got %b want %b", name, i, got, e);
         end
         @(posedge clk);
         model_commit();
      end
      @(negedge clk);
      idle();
   endtask

   task automatic check_stats(input string name);
      #1;
      tests++;
      if (stat_branches !== 16'(m_br)) begin
         fails++; $display("FAIL %s stat_branches: got %0d want %0d", name, stat_branches, m_br);
      end
      tests++;
      if (stat_mispredicts !== 16'(m_mis)) begin
         fails++; $display("FAIL %s stat_mispredicts: got %0d want %0d", name, stat_mispredicts, m_mis);
      end
   endtask

   task automatic test_beq_train();
      vec_t v[$];
      v.push_back('{1'b1, 3'b100, 1'b0, 32'd5, 32'd5, 1'b0, 32'h100});
      v.push_back('{1'b1, 3'b100, 1'b0, 32'd5, 32'd5, 1'b1, 32'h100});
      v.push_back('{1'b1, 3'b100, 1'b0, 32'd5, 32'd5, 1'b1, 32'h100});
      run_vectors("beq_train", v, 32'h100);
      check_stats("beq_train");
      tests++;
      if (bus.if_pred_taken !== 1'b1 || m_bht[idx_of(32'h100)] !== 2'b11) begin
         fails++;
         $display("FAIL beq_saturate: got pred %b ctr_model %b want 1/11", bus.if_pred_taken, m_bht[idx_of(32'h100)]);
      end
   endtask

   task automatic test_compare();
      vec_t v[$];
      v.push_back('{1'b1, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h300});
      v.push_back('{1'b1, 3'b110, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h300});
      v.push_back('{1'b1, 3'b111, 1'b0, 32'd7, 32'd7, 1'b0, 32'h304});
      v.push_back('{1'b1, 3'b111, 1'b1, 32'h8000_0000, 32'd3, 1'b1, 32'h304});
      v.push_back('{1'b1, 3'b101, 1'b1, 32'd9, 32'd9, 1'b1, 32'h308});
      for (int i = 0; i < 24; i++)
         v.push_back('{1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? 32'd42 : $urandom,
                       ($urandom_range(0, 3) == 0) ? 32'd42 : $urandom,
                       1'($urandom_range(0, 1)), {$urandom_range(0, 255), 2'b00}});
      run_vectors("compare", v, 32'h300);
      check_stats("compare");
   endtask

   task automatic test_jump_nonbranch();
      vec_t v[$];
      int br_before;
      br_before = m_br;
      v.push_back('{1'b1, 3'b010, 1'b0, 32'd1, 32'd2, 1'b0, 32'h100});
      v.push_back('{1'b1, 3'b001, 1'b0, 32'd1, 32'd2, 1'b1, 32'h100});
      v.push_back('{1'b1, 3'b011, 1'b0, 32'd4, 32'd4, 1'b0, 32'h100});
      v.push_back('{1'b1, 3'b000, 1'b0, 32'd4, 32'd4, 1'b1, 32'h100});
      v.push_back('{1'b0, 3'b100, 1'b0, 32'd4, 32'd4, 1'b1, 32'h100});
      run_vectors("jump", v, 32'h100);
      #1;
      tests++;
      if (stat_branches !== 16'(br_before)) begin
         fails++; $display("FAIL jump_no_stat: got %0d want %0d", stat_branches, br_before);
      end
   endtask

   task automatic test_read_during_write();
      vec_t v[$];
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      v.push_back('{1'b1, 3'b101, 1'b0, 32'd1, 32'd2, 1'b0, 32'h200});
      run_vectors("rdw", v, 32'h200);
      #1;
      tests++;
      if (bus.if_pred_taken !== m_bht[idx_of(32'h200)][1]) begin
         fails++; $display("FAIL rdw_next_cycle: got %b want %b", bus.if_pred_taken, m_bht[idx_of(32'h200)][1]);
      end
      // Hold a taken resolve across a reset edge: it must be dropped.
      @(negedge clk);
      drive(1'b1, 3'b101, 1'b0, 32'd1, 32'd2, 1'b0, 32'h200, 32'h200);
      void'(exp_q.pop_front());
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      tests++;
      if (bus.if_pred_taken !== 1'b0) begin
         fails++; $display("FAIL rst_async_pred: got %b want 0", bus.if_pred_taken);
      end
      tests++;
      if (stat_branches !== 16'd0 || stat_mispredicts !== 16'd0) begin
         fails++; $display("FAIL rst_async_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
      end
      tests++;
      if (bus.ex_pc_a_src !== 1'b1 || bus.ex_mispredict !== 1'b1) begin
         fails++; $display("FAIL rst_comb_follow: got a=%b mis=%b want 1/1", bus.ex_pc_a_src, bus.ex_mispredict);
      end
      @(posedge clk);
      @(negedge clk);
      idle();
      rst = 1'b0;
      #1;
      tests++;
      if (bus.if_pred_taken !== 1'b0 || stat_branches !== 16'd0) begin
         fails++; $display("FAIL rst_drop_inflight: got pred=%b br=%0d want 0/0", bus.if_pred_taken, stat_branches);
      end
   endtask

   task automatic test_stat_saturate();
      int m4;
      m4 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus4.ex_valid = 1'b1; bus4.ex_branch = 3'b100; bus4.ex_unsigned = 1'b0;
         bus4.ex_rs1 = 32'd3; bus4.ex_rs2 = 32'd3; bus4.ex_pred_taken = 1'b0;
         bus4.ex_pc = 32'(i * 4); bus4.if_pc = 32'(i * 4);
         @(posedge clk);
         if (m4 < 15) m4++;
         if (i == 9 || i == 19) begin
            #1;
            tests++;
            if (stat4_branches !== 4'(m4) || stat4_mispredicts !== 4'(m4)) begin
               fails++;
               $display("FAIL stat_sat[%0d]: got %0d/%0d want %0d/%0d", i, stat4_branches, stat4_mispredicts, m4, m4);
            end
         end
      end
      @(negedge clk);
      bus4.ex_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_beq_train();
      test_compare();
      test_jump_nonbranch();
      test_read_during_write();
      test_stat_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
